// File: rtl/mem_arbiter_pkg.sv
// Shared bus types, FSM state enum and request mapping helpers for the
// instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_e;

  localparam logic [2:0]  IBUS_SIZE = 3'b010;
  localparam int unsigned STARVE_W  = 4;

  // Fetches are always 32-bit reads.
  function automatic cbus_req_t map_ireq(input ibus_req_t r);
    cbus_req_t c;
    c       = '0;
    c.valid = 1'b1;
    c.addr  = r.addr;
    c.size  = IBUS_SIZE;
    return c;
  endfunction

  function automatic cbus_req_t map_dreq(input dbus_req_t r);
    cbus_req_t c;
    c          = '0;
    c.valid    = 1'b1;
    c.is_write = |r.strobe;
    c.addr     = r.addr;
    c.size     = r.size;
    c.strobe   = r.strobe;
    c.data     = r.data;
    return c;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Grant decision: data bus wins ties unless the fetch side has waited
// through STARVE_LIMIT consecutive data grants.
module arb_select
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                ivalid,
  input  logic                dvalid,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                grant_i,
  output logic                grant_d
);

  logic starved;

  always_comb begin
    starved = (starve_cnt >= STARVE_W'(STARVE_LIMIT));
    grant_d = dvalid && !(ivalid && starved);
    grant_i = ivalid && !grant_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) to single memory port arbiter with a latched
// request buffer, starvation counter and per-owner response routing.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  cbus_req_t           buf_q, buf_d;
  logic                grant_i, grant_d;
  logic                busy, done;

  arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb_select (
    .ivalid    (ireq.valid),
    .dvalid    (dreq.valid),
    .starve_cnt(starve_q),
    .grant_i   (grant_i),
    .grant_d   (grant_d)
  );

  // Reset gates busy so an abandoned transaction can never complete.
  always_comb begin
    busy = (state_q != IDLE) && !reset;
    done = busy && cresp.ready && cresp.last;
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    buf_d    = buf_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = SERVE_D;
          buf_d   = map_dreq(dreq);
          if (ireq.valid && (starve_q != '1)) starve_d = starve_q + 1'b1;
        end else if (grant_i) begin
          state_d  = SERVE_I;
          buf_d    = map_ireq(ireq);
          starve_d = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    creq       = buf_q;
    creq.valid = busy;
    iresp      = '0;
    dresp      = '0;
    if (done && (state_q == SERVE_I)) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = buf_q.addr[2] ? cresp.data[63:32] : cresp.data[31:0];
    end
    if (done && (state_q == SERVE_D)) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = cresp.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      buf_q    <= buf_d;
    end
  end

endmodule
